trigger_network_controller: RTL

Network-level sequencer for the per-actor trigger FSMs of one accelerated partition. It latches an actor enable mask and fans a one-cycle start pulse out to every enabled trigger. It computes the phase-gated all_sleep / all_sync / all_sync_wait aggregates the triggers consume, and reports partition completion through an ap_start/ap_done handshake. It sits between the host-facing control interface and the array of trigger instances.

---
 rtl/trigger_network_controller_pkg.sv | 21 ++
 rtl/trigger_network_controller_if.sv | 33 +++
 rtl/trigger_network_controller_mask_reduce.sv | 22 ++
 rtl/trigger_network_controller.sv | 91 +++++++++
 4 files changed

// File: rtl/trigger_network_controller_pkg.sv
// Shared types for the trigger network: controller state encoding and a
// width-generic saturating increment used by the statistics counters.
package trigger_network_controller_pkg;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_START = 3'd1,
    CTRL_RUN   = 3'd2,
    CTRL_SYNC  = 3'd3,
    CTRL_DRAIN = 3'd4,
    CTRL_DONE  = 3'd5
  } ctrl_state_t;

  // Callers zero-extend into 64 bits and size-cast the result back to w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int w);
    logic [63:0] max_value;
    max_value = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (value >= max_value) ? max_value : value + 64'd1;
  endfunction

endpackage

// File: rtl/trigger_network_controller_if.sv
// Host handshake and trigger-array status/broadcast bundle of the network controller.
interface trigger_network_controller_if #(
  parameter int NUM_ACTORS = 4,
  parameter int CNT_WIDTH  = 32
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_ready;
  logic                  ap_idle;
  logic [NUM_ACTORS-1:0] actor_mask;
  logic [NUM_ACTORS-1:0] actor_start;
  logic [NUM_ACTORS-1:0] actor_idle;
  logic [NUM_ACTORS-1:0] actor_sleep;
  logic [NUM_ACTORS-1:0] actor_sync_exec;
  logic [NUM_ACTORS-1:0] actor_sync_wait;
  logic                  all_sleep;
  logic                  all_sync;
  logic                  all_sync_wait;
  logic [CNT_WIDTH-1:0]  run_cycles;
  logic [CNT_WIDTH-1:0]  sync_rounds;

  modport master (
    output ap_start, actor_mask, actor_idle, actor_sleep, actor_sync_exec, actor_sync_wait,
    input  ap_done, ap_ready, ap_idle, actor_start, all_sleep, all_sync, all_sync_wait,
           run_cycles, sync_rounds
  );

  modport slave (
    input  ap_start, actor_mask, actor_idle, actor_sleep, actor_sync_exec, actor_sync_wait,
    output ap_done, ap_ready, ap_idle, actor_start, all_sleep, all_sync, all_sync_wait,
           run_cycles, sync_rounds
  );
endinterface

// File: rtl/trigger_network_controller_mask_reduce.sv
// Masked AND-reductions over trigger status vectors; a disabled actor always
// counts as sleeping, synced, waiting and idle.
module trigger_mask_reduce #(
  parameter int NUM_ACTORS = 4
) (
  input  logic [NUM_ACTORS-1:0] mask,
  input  logic [NUM_ACTORS-1:0] sleep,
  input  logic [NUM_ACTORS-1:0] sync_exec,
  input  logic [NUM_ACTORS-1:0] sync_wait,
  input  logic [NUM_ACTORS-1:0] idle,
  output logic                  sleep_ok,
  output logic                  sync_ok,
  output logic                  wait_ok,
  output logic                  idle_ok
);

  assign sleep_ok = &(sleep | ~mask);
  assign sync_ok  = &(sync_exec | sync_wait | ~mask);
  assign wait_ok  = &(sync_wait | ~mask);
  assign idle_ok  = &(idle | ~mask);

endmodule

// File: rtl/trigger_network_controller.sv
// Partition-level sequencer: fans a start pulse to enabled triggers, gates the
// broadcast aggregates by phase and reports completion on ap_done.
//
// state      | meaning
// CTRL_IDLE  | waiting for ap_start, ap_idle high
// CTRL_START | one-cycle actor_start pulse to enabled triggers
// CTRL_RUN   | actors running until all enabled actors sleep
// CTRL_SYNC  | sync rounds until all enabled actors reach sync_wait
// CTRL_DRAIN | waiting for all enabled actors to go idle
// CTRL_DONE  | one-cycle ap_done / ap_ready
module trigger_network_controller
  import trigger_network_controller_pkg::*;
#(
  parameter int NUM_ACTORS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  trigger_network_controller_if.slave   bus
);

  ctrl_state_t           state_q, state_d;
  logic [NUM_ACTORS-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  run_cycles_q;
  logic [CNT_WIDTH-1:0]  sync_rounds_q;
  logic                  sleep_ok, sync_ok, wait_ok, idle_ok;
  logic                  accept;
  logic                  counting;

  trigger_mask_reduce #(.NUM_ACTORS(NUM_ACTORS)) u_reduce (
    .mask      (mask_q),
    .sleep     (bus.actor_sleep),
    .sync_exec (bus.actor_sync_exec),
    .sync_wait (bus.actor_sync_wait),
    .idle      (bus.actor_idle),
    .sleep_ok  (sleep_ok),
    .sync_ok   (sync_ok),
    .wait_ok   (wait_ok),
    .idle_ok   (idle_ok)
  );

  assign accept   = (state_q == CTRL_IDLE) && bus.ap_start;
  assign counting = (state_q == CTRL_RUN) || (state_q == CTRL_SYNC) || (state_q == CTRL_DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE:  if (bus.ap_start) state_d = CTRL_START;
      CTRL_START: state_d = CTRL_RUN;
      CTRL_RUN:   if (sleep_ok) state_d = CTRL_SYNC;
      CTRL_SYNC:  if (sync_ok && wait_ok) state_d = CTRL_DRAIN;
      CTRL_DRAIN: if (idle_ok) state_d = CTRL_DONE;
      CTRL_DONE:  state_d = CTRL_IDLE;
      default:    state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= CTRL_IDLE;
    else           state_q <= state_d;
  end

  // Counters are cleared on accept so they hold last-run values through IDLE.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mask_q        <= '0;
      run_cycles_q  <= '0;
      sync_rounds_q <= '0;
    end else if (accept) begin
      mask_q        <= bus.actor_mask;
      run_cycles_q  <= '0;
      sync_rounds_q <= '0;
    end else begin
      if (counting)
        run_cycles_q <= CNT_WIDTH'(sat_inc(64'(run_cycles_q), CNT_WIDTH));
      if ((state_q == CTRL_SYNC) && sync_ok && !wait_ok)
        sync_rounds_q <= CNT_WIDTH'(sat_inc(64'(sync_rounds_q), CNT_WIDTH));
    end
  end

  assign bus.ap_idle       = (state_q == CTRL_IDLE);
  assign bus.ap_done       = (state_q == CTRL_DONE);
  assign bus.ap_ready      = (state_q == CTRL_DONE);
  assign bus.actor_start   = (state_q == CTRL_START) ? mask_q : '0;
  assign bus.all_sleep     = (state_q == CTRL_RUN) && sleep_ok;
  assign bus.all_sync      = (state_q == CTRL_SYNC) && sync_ok;
  assign bus.all_sync_wait = (state_q == CTRL_SYNC) && sync_ok && wait_ok;
  assign bus.run_cycles    = run_cycles_q;
  assign bus.sync_rounds   = sync_rounds_q;

endmodule
